// File: rtl/up_down_mod_counter.sv
// Bounded up/down counter: modulus 0..limit, wrap or saturate at either end,
// synchronous load and a registered terminal-count pulse.
module up_down_mod_counter #(
  parameter int             N         = 4,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ctrl,
  input  logic         sat,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  output logic [N-1:0] q,
  output logic         tc
);

  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;

  // Boundaries are detected by explicit compares, so limit == 2**N-1 never
  // depends on the adder rolling over.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (q_q > limit) begin
        q_d = limit;
      end else if (!ctrl) begin
        if (q_q == limit) begin
          tc_d = 1'b1;
          q_d  = sat ? q_q : '0;
        end else begin
          q_d = q_q + N'(1);
        end
      end else begin
        if (q_q == '0) begin
          tc_d = 1'b1;
          q_d  = sat ? q_q : limit;
        end else begin
          q_d = q_q - N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q  <= RESET_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule
